// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: assembles four little-endian bytes into one instruction and
// holds it for decode until acknowledged. Optional inter-byte timeout under macro FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int DATAWIDTH = 32,
    parameter int PCWIDTH   = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [7:0]           byteIn,
    input  logic                 byteValid,
    output logic                 byteReady,
    output logic [DATAWIDTH-1:0] instruction,
    output logic                 instrValid,
    input  logic                 instrAck,
    output logic [PCWIDTH-1:0]   pc,
    output logic                 timeoutErr
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_cnt;
    logic [DATAWIDTH-1:0]   r_asm;
    logic [PCWIDTH-1:0]     r_pc;
    logic                   w_accept;
    logic                   w_ack;
    logic                   w_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // flush outranks both byte acceptance and acknowledge
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ack        = 1'b0;
        byteReady    = (r_state == COLLECT);
        if (flush) begin
            w_state_next = COLLECT;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (byteValid) begin
                        w_accept = 1'b1;
                        if (r_cnt == 2'd3) begin
                            w_state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instrAck) begin
                        w_ack        = 1'b1;
                        w_state_next = COLLECT;
                    end
                end
                default: w_state_next = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 2'd0;
            r_asm <= '0;
            r_pc  <= '0;
        end else if (flush) begin
            r_cnt <= 2'd0;
            r_asm <= '0;
            r_pc  <= '0;
        end else begin
            if (w_accept) begin
                r_asm[{r_cnt, 3'b000} +: 8] <= byteIn;
                r_cnt                       <= r_cnt + 2'd1;
            end else if (w_timeout) begin
                r_cnt <= 2'd0;
                r_asm <= '0;
            end
            if (w_ack) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] r_idle;
    logic              r_tout;
    logic              w_idle_run;
    logic [IDLE_W-1:0] w_idle_inc;

    // idle time only counts between bytes of a partially assembled instruction
    assign w_idle_run = (r_state == COLLECT) && (r_cnt != 2'd0) && !w_accept && !flush;
    assign w_idle_inc = r_idle + 1'b1;
    assign w_timeout  = w_idle_run && (w_idle_inc == IDLE_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
            r_tout <= 1'b0;
        end else begin
            r_tout <= w_timeout;
            if (w_idle_run && !w_timeout) begin
                r_idle <= w_idle_inc;
            end else begin
                r_idle <= '0;
            end
        end
    end

    assign timeoutErr = r_tout;
`else
    assign w_timeout  = 1'b0;
    assign timeoutErr = 1'b0;
`endif

    assign instrValid  = (r_state == HOLD);
    assign instruction = instrValid ? r_asm : '0;
    assign pc          = r_pc;

endmodule
